// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles every non-clock/non-reset signal of the X9 fetch stage.
//
// Signal summary
//   Start        core -> fetch  level run request
//   prog_end     core -> fetch  address of the last program instruction
//   instr_addr   fetch -> imem  instruction-memory address (= PC)
//   instr_data   imem -> fetch  read data, combinational from instr_addr
//   instr_out    fetch -> dec   instr_data while running, else 0
//   opcode       fetch -> dec   instr_out[IW-1:IW-5]
//   BranchInst   dec -> fetch   current instruction is a branch
//   BranchTaken  alu -> fetch   branch condition already resolved
//   lut_we       cfg -> fetch   branch-target table write enable
//   lut_waddr    cfg -> fetch   table write index
//   lut_wdata    cfg -> fetch   table write data (absolute address)
//   Done         fetch -> core  program finished
//   running      fetch -> core  fetch FSM is in RUN
//   retired      fetch -> core  instructions retired since last Start
//
// Modports
//   master : the fetch unit itself (drives the instruction address)
//   slave  : the surrounding core / memory / decoder side
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int TIW  = 4,
  parameter int CNTW = 16
);

  logic            Start;
  logic [PCW-1:0]  prog_end;
  logic [PCW-1:0]  instr_addr;
  logic [IW-1:0]   instr_data;
  logic [IW-1:0]   instr_out;
  logic [4:0]      opcode;
  logic            BranchInst;
  logic            BranchTaken;
  logic            lut_we;
  logic [TIW-1:0]  lut_waddr;
  logic [PCW-1:0]  lut_wdata;
  logic            Done;
  logic            running;
  logic [CNTW-1:0] retired;

  modport master (
    input  Start,
    input  prog_end,
    output instr_addr,
    input  instr_data,
    output instr_out,
    output opcode,
    input  BranchInst,
    input  BranchTaken,
    input  lut_we,
    input  lut_waddr,
    input  lut_wdata,
    output Done,
    output running,
    output retired
  );

  modport slave (
    output Start,
    output prog_end,
    input  instr_addr,
    output instr_data,
    input  instr_out,
    input  opcode,
    output BranchInst,
    output BranchTaken,
    output lut_we,
    output lut_waddr,
    output lut_wdata,
    input  Done,
    input  running,
    input  retired
  );

endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the single-cycle X9 core. Owns the program
// counter, the run/halt sequencing, a 2**TIW-entry branch-target table and a
// saturating retired-instruction counter.
//
// Ports
//   Clk    rising-edge clock
//   Reset  asynchronous, active-high reset
//   bus    fetch_unit_if.master (see interface file for the signal list)
//
// FSM
//   state  | meaning
//   IDLE   | waiting for Start; PC forced to 0, retired count held
//   RUN    | one instruction fetched and retired per clock
//   DONE   | last instruction retired; waits for Start to drop
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int TIW  = 4,
  parameter int CNTW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_unit_if.master  bus
);

  localparam int NTGT = 2 ** TIW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic [PCW-1:0]  tgt_q [NTGT];

  logic            run_w;
  logic            at_end_w;
  logic            take_br_w;
  logic [TIW-1:0]  br_idx_w;
  logic [PCW-1:0]  br_tgt_w;
  logic [PCW-1:0]  pc_inc_w;
  logic [CNTW-1:0] retired_inc_w;
  logic [IW-1:0]   instr_gated_w;

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------
  assign run_w     = (state_q == S_RUN);
  assign at_end_w  = (pc_q == bus.prog_end);
  assign take_br_w = bus.BranchInst && bus.BranchTaken;
  assign br_idx_w  = bus.instr_data[TIW-1:0];

  // Asynchronous table read: a same-edge write is not yet visible here, so a
  // branch racing a write to its own index naturally uses the old entry.
  assign br_tgt_w  = tgt_q[br_idx_w];

  // PC increment wraps modulo 2**PCW by construction of the width.
  assign pc_inc_w  = pc_q + PCW'(1);

  // Retired count saturates at all-ones instead of rolling over.
  assign retired_inc_w = (&retired_q) ? retired_q : (retired_q + CNTW'(1));

  // -------------------------------------------------------------------------
  // FSM state register and PC / counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / next-PC logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;

    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (bus.Start) begin
          state_d   = S_RUN;
          retired_d = '0;
        end
      end

      S_RUN: begin
        retired_d = retired_inc_w;
        if (at_end_w) begin
          // End check has priority over any branch on the last instruction.
          state_d = S_DONE;
        end else if (take_br_w) begin
          pc_d = br_tgt_w;
        end else begin
          pc_d = pc_inc_w;
        end
      end

      S_DONE: begin
        // Start must fall before a new run can be requested.
        if (!bus.Start) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Branch-target table: synchronous write in any state, cleared by reset
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NTGT; i++) begin
        tgt_q[i] <= '0;
      end
    end else if (bus.lut_we) begin
      tgt_q[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Outside RUN the decoder sees an all-zero word (opcode 00000).
  assign instr_gated_w  = run_w ? bus.instr_data : '0;

  assign bus.instr_addr = pc_q;
  assign bus.instr_out  = instr_gated_w;
  assign bus.opcode     = instr_gated_w[IW-1:IW-5];
  assign bus.Done       = (state_q == S_DONE);
  assign bus.running    = run_w;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus ();

  fetch_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Program image seen by the fetch unit: memory word, decoder BranchInst and
  // resolved branch condition, all indexed by instruction address.
  logic [8:0] imem  [1024];
  logic       binst [1024];
  logic       btk   [1024];
  logic [9:0] mtab  [16];

  assign bus.instr_data  = imem[bus.instr_addr];
  assign bus.BranchInst  = binst[bus.instr_addr];
  assign bus.BranchTaken = btk[bus.instr_addr];

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      imem[i]  = 9'($urandom);
      binst[i] = 1'b0;
      btk[i]   = 1'b0;
    end
  endtask

  task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
    bus.lut_we    = 1'b1;
    bus.lut_waddr = idx;
    bus.lut_wdata = data;
    step();
    bus.lut_we    = 1'b0;
    mtab[idx]     = data;
  endtask

  // Runs one program from IDLE and compares every cycle against a walk of the
  // program image. One optional table write is issued on cycle wr_at.
  task automatic run_program(input logic [9:0] pe, input bit hold, input int wr_at,
                             input logic [3:0] wi, input logic [9:0] wd,
                             input int limit, input string name);
    int pc;
    int cnt;
    bit ended;
    pc = 0;
    cnt = 0;
    ended = 1'b0;
    bus.prog_end = pe;
    bus.Start    = 1'b1;
    step();
    if (!hold) bus.Start = 1'b0;
    for (int c = 0; c < limit && !ended; c++) begin
      checks++;
      if (bus.instr_addr !== pc[9:0] || bus.running !== 1'b1 || bus.Done !== 1'b0 ||
          bus.retired !== cnt[15:0]) begin
        errors++;
        $display("FAIL %s run c%0d: addr=%h run=%b done=%b ret=%0d, need addr=%h run=1 done=0 ret=%0d",
                 name, c, bus.instr_addr, bus.running, bus.Done, bus.retired, pc[9:0], cnt);
      end
      checks++;
      if (bus.instr_out !== imem[pc] || bus.opcode !== imem[pc][8:4]) begin
        errors++;
        $display("FAIL %s instr c%0d: instr_out=%h opcode=%h, need %h / %h",
                 name, c, bus.instr_out, bus.opcode, imem[pc], imem[pc][8:4]);
      end
      if (c == wr_at) begin
        bus.lut_we    = 1'b1;
        bus.lut_waddr = wi;
        bus.lut_wdata = wd;
      end
      step();
      bus.lut_we = 1'b0;
      if (pc == int'(pe))             ended = 1'b1;
      else if (binst[pc] && btk[pc])  pc = int'(mtab[imem[pc][3:0]]);
      else                            pc = (pc + 1) % 1024;
      if (c == wr_at) mtab[wi] = wd;
      if (cnt < 65535) cnt++;
    end

    if (!ended) begin
      // Program did not reach its end within the budget: abort with reset.
      bus.Start = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.instr_addr !== 10'd0 || bus.Done !== 1'b0 || bus.running !== 1'b0 ||
          bus.retired !== 16'd0) begin
        errors++;
        $display("FAIL %s abort: addr=%h done=%b run=%b ret=%0d, need 0 0 0 0",
                 name, bus.instr_addr, bus.Done, bus.running, bus.retired);
      end
      for (int i = 0; i < 16; i++) mtab[i] = 10'd0;
      #1 rst = 1'b0;
      step();
      return;
    end

    checks++;
    if (bus.Done !== 1'b1 || bus.running !== 1'b0 || bus.instr_addr !== pe ||
        bus.retired !== cnt[15:0] || bus.instr_out !== 9'd0) begin
      errors++;
      $display("FAIL %s done: done=%b run=%b addr=%h ret=%0d iout=%h, need 1 0 %h %0d 000",
               name, bus.Done, bus.running, bus.instr_addr, bus.retired, bus.instr_out, pe, cnt);
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        step();
        checks++;
        if (bus.Done !== 1'b1 || bus.instr_addr !== pe || bus.retired !== cnt[15:0]) begin
          errors++;
          $display("FAIL %s hold k%0d: done=%b addr=%h ret=%0d, need 1 %h %0d",
                   name, k, bus.Done, bus.instr_addr, bus.retired, pe, cnt);
        end
      end
      bus.Start = 1'b0;
    end
    step();
    checks++;
    if (bus.Done !== 1'b0 || bus.running !== 1'b0 || bus.instr_addr !== 10'd0 ||
        bus.retired !== cnt[15:0] || bus.opcode !== 5'd0) begin
      errors++;
      $display("FAIL %s idle: done=%b run=%b addr=%h ret=%0d op=%h, need 0 0 000 %0d 00",
               name, bus.Done, bus.running, bus.instr_addr, bus.retired, bus.opcode, cnt);
    end
  endtask

  task automatic test_reset();
    clear_prog();
    for (int i = 0; i < 16; i++) mtab[i] = 10'd0;
    imem[0] = 9'h1A5;
    bus.Start = 1'b0; bus.prog_end = 10'd0;
    bus.lut_we = 1'b0; bus.lut_waddr = 4'd0; bus.lut_wdata = 10'd0;
    rst = 1'b1;
    #12;
    checks++;
    if (bus.instr_addr !== 10'd0 || bus.Done !== 1'b0 || bus.running !== 1'b0 ||
        bus.retired !== 16'd0 || bus.instr_out !== 9'd0 || bus.opcode !== 5'd0) begin
      errors++;
      $display("FAIL reset: addr=%h done=%b run=%b ret=%0d iout=%h op=%h, need all 0",
               bus.instr_addr, bus.Done, bus.running, bus.retired, bus.instr_out, bus.opcode);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_linear();
    clear_prog();
    run_program(10'd3, 1'b0, -1, 4'd0, 10'd0, 20, "linear");
  endtask

  task automatic test_branch();
    clear_prog();
    lut_write(4'd5, 10'h040);
    imem[2][3:0] = 4'd5;
    binst[2] = 1'b1; btk[2] = 1'b1;
    run_program(10'h045, 1'b0, -1, 4'd0, 10'd0, 100, "br_taken");
    btk[2] = 1'b0;
    run_program(10'h006, 1'b0, -1, 4'd0, 10'd0, 100, "br_not_taken");
  endtask

  task automatic test_write_collision();
    clear_prog();
    imem[2][3:0]    = 4'd5; binst[2]    = 1'b1; btk[2]    = 1'b1;
    imem[10'h040][3:0] = 4'd5; binst[10'h040] = 1'b1; btk[10'h040] = 1'b1;
    // Cycle 2 is the branch at PC=2: write and branch on the same edge.
    run_program(10'h082, 1'b0, 2, 4'd5, 10'h080, 100, "collision");
  endtask

  task automatic test_reset_mid_run();
    clear_prog();
    bus.prog_end = 10'd20;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int c = 0; c < 7; c++) step();
    checks++;
    if (bus.instr_addr !== 10'd7 || bus.retired !== 16'd7) begin
      errors++;
      $display("FAIL midrst pre: addr=%h ret=%0d, need 007 7", bus.instr_addr, bus.retired);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.instr_addr !== 10'd0 || bus.Done !== 1'b0 || bus.running !== 1'b0 ||
        bus.retired !== 16'd0 || bus.instr_out !== 9'd0) begin
      errors++;
      $display("FAIL midrst: addr=%h done=%b run=%b ret=%0d iout=%h, need all 0",
               bus.instr_addr, bus.Done, bus.running, bus.retired, bus.instr_out);
    end
    for (int i = 0; i < 16; i++) mtab[i] = 10'd0;
    #1 rst = 1'b0;
    step();
    // Table was cleared: first branch via index 5 lands on 0, the second
    // (after a write on cycle 3) lands on 3.
    imem[2][3:0] = 4'd5; binst[2] = 1'b1; btk[2] = 1'b1;
    run_program(10'd3, 1'b0, 3, 4'd5, 10'd3, 40, "table_cleared");
  endtask

  task automatic test_done_hold();
    clear_prog();
    run_program(10'd4, 1'b1, -1, 4'd0, 10'd0, 20, "done_hold");
    run_program(10'd2, 1'b0, -1, 4'd0, 10'd0, 20, "restart");
  endtask

  task automatic test_wrap_and_end_branch();
    clear_prog();
    lut_write(4'd1, 10'h3FE);
    imem[3][3:0] = 4'd1; binst[3] = 1'b1; btk[3] = 1'b1;
    imem[5][3:0] = 4'd1; binst[5] = 1'b1; btk[5] = 1'b1;
    run_program(10'h005, 1'b0, 4, 4'd1, 10'h005, 40, "wrap_endbr");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_prog();
      for (int i = 0; i < 4; i++) lut_write(4'($urandom), 10'($urandom_range(0, 63)));
      for (int a = 0; a < 64; a++) begin
        binst[a] = ($urandom_range(0, 7) == 0);
        btk[a]   = 1'($urandom);
      end
      run_program(10'($urandom_range(0, 63)), 1'($urandom), $urandom_range(0, 20),
                  4'($urandom), 10'($urandom_range(0, 63)), 150, "random");
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_branch();
    test_write_collision();
    test_reset_mid_run();
    test_done_hold();
    test_wrap_and_end_branch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
